shift_in_param: RTL and testbench
=================================

Name: shift_in_param

Overview:
Parametrised digit-entry shift register, the successor to the fixed 4-bit x 4-digit shift-in state machine. It captures one DIGIT_W-bit digit per debounced active-low key strobe and accumulates up to DIGITS digits. It supports selectable shift direction, backspace, clear, commit-to-holding-register and a selectable full policy. It sits between the keypad decoder and the arithmetic/display datapath.

Parameters:
DIGIT_W, 4, width of one digit (din)
DIGITS, 4, number of digits held; buffer width W = DIGIT_W*DIGITS
MSB_FIRST, 1, 1: new digit enters LS position and the buffer shifts left; 0: new digit enters MS position and the buffer shifts right
FULL_MODE, 0, 0: presses ignored when full; 1: shift anyway, discard the oldest digit
DEBOUNCE, 2, consecutive cycles key_n must be high before a new press is accepted (>=1)
CLR_ON_COMMIT, 1, 1: buffer and count cleared on commit

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-low (rst==0 at a rising edge resets)
key_n  in  1  digit strobe, active-low (low = key pressed)
din  in  DIGIT_W  digit value, sampled on an accepted press
clr  in  1  synchronous clear of the buffer
bksp  in  1  remove the most recent digit
commit  in  1  copy the buffer to word and pulse done
dout  out  W  live entry buffer
count  out  $clog2(DIGITS+1)  digits held
full  out  1  count==DIGITS
ena  out  1  one-cycle pulse: digit accepted this cycle
done  out  1  one-cycle pulse: commit executed
word  out  W  committed value, held until the next commit

Behaviour:
- All outputs are registered. Reset values: dout=0, count=0, full=0, ena=0, done=0, word=0, FSM=HELD, debounce counter=0.
- FSM states:
  - IDLE (armed): on key_n==0, accept the press and go to HELD.
  - HELD: key_n==1 increments the debounce counter; key_n==0 zeroes it. When the counter reaches DEBOUNCE, go to IDLE and zero the counter.
- Reset lands in HELD, so a key held low through reset is never captured until it has been released for DEBOUNCE cycles.
- Accepted press, with the update visible after the same edge (latency 1 clock):
  - MSB_FIRST=1: dout <= {dout[W-DIGIT_W-1:0], din}.
  - MSB_FIRST=0: dout <= {din, dout[W-1:DIGIT_W]}.
  - count increments and ena=1 for one cycle.
- Full with FULL_MODE=0: the press is consumed (FSM goes to HELD), but dout, count and ena are unchanged (ena=0).
- Full with FULL_MODE=1: the shift occurs, count stays at DIGITS, and ena=1.
- bksp with count>0: count decrements.
  - MSB_FIRST=1: dout <= {DIGIT_W zeros, dout[W-1:DIGIT_W]}.
  - MSB_FIRST=0: dout <= {dout[W-DIGIT_W-1:0], DIGIT_W zeros}.
  - bksp with count==0 is a no-op.
  - bksp is level-sensitive; each high cycle removes one digit.
- clr: dout=0, count=0. The FSM and word are unaffected.
- commit: word <= dout and done=1 for one cycle. If CLR_ON_COMMIT=1, dout=0 and count=0 after the same edge. Commit with count==0 still pulses done and sets word=0.
- Simultaneous events, priority clr > commit > bksp > press. Only the highest-priority action modifies dout/count. A press coincident with clr, commit or bksp is consumed (the FSM still goes to HELD) but no digit is captured and ena=0.
- full is combinationally equal to (count==DIGITS) of the registered count.
- Reset mid-press or mid-debounce: all state returns to the reset values above; word is lost.

Test Plan:
1. DIGIT_W=4, DIGITS=4, MSB_FIRST=1, DEBOUNCE=2. Reset, then key_n high for 2 cycles. Press 5, 9, 6, A (each low 2 cycles, high 3 cycles) -> four ena pulses, dout=0x596A, count=4, full=1.
2. From 0x596A, press F:
   - FULL_MODE=0 -> dout=0x596A, no ena.
   - FULL_MODE=1 -> dout=0x96AF, ena=1, count=4.
3. From 0x596A, bksp for 1 cycle -> dout=0x0596, count=3, full=0. clr then bksp -> dout=0, count stays 0.
4. key_n low for 10 cycles -> exactly one ena. Bounce of high 1 cycle then low -> no second capture. High 2 cycles then low -> second capture.
5. With dout=0x0596, assert commit and a press in the same cycle -> done=1 for 1 cycle, word=0x0596, dout=0, count=0, ena=0. A later release plus press of 3 -> dout=0x0003.
6. MSB_FIRST=0: press 5 then 9 -> dout=0x5000 then 0x9500. Hold key_n low through a reset pulse -> no capture until key_n has been high for 2 cycles and pressed again.

Source files
------------

// File: rtl/shift_in_param.sv
// Parametrised digit-entry shift register: captures one debounced key press per digit
// into a DIGITS-deep buffer, with backspace, clear, commit and a selectable full policy.
module shift_in_param #(
    parameter int DIGIT_W       = 4,
    parameter int DIGITS        = 4,
    parameter int MSB_FIRST     = 1,
    parameter int FULL_MODE     = 0,
    parameter int DEBOUNCE      = 2,
    parameter int CLR_ON_COMMIT = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               key_n,
    input  logic [DIGIT_W-1:0]                 din,
    input  logic                               clr,
    input  logic                               bksp,
    input  logic                               commit,
    output logic [DIGIT_W*DIGITS-1:0]          dout,
    output logic [$clog2(DIGITS+1)-1:0]        count,
    output logic                               full,
    output logic                               ena,
    output logic                               done,
    output logic [DIGIT_W*DIGITS-1:0]          word
);

    localparam int W  = DIGIT_W * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam int DW = $clog2(DEBOUNCE + 1);

    // IDLE: armed for the next press. HELD: waiting for DEBOUNCE high cycles.
    typedef enum logic {IDLE, HELD} state_t;

    state_t        state;
    logic [DW-1:0] db_cnt;

    logic          press;
    logic [W-1:0]  shift_val;
    logic [W-1:0]  bksp_val;

    assign full = (count == CW'(DIGITS));

    always_comb begin
        press     = (state == IDLE) && !key_n;
        shift_val = '0;
        bksp_val  = '0;
        if (MSB_FIRST != 0) begin
            shift_val = (dout << DIGIT_W) | W'(din);
            bksp_val  = dout >> DIGIT_W;
        end else begin
            shift_val = (dout >> DIGIT_W) | (W'(din) << (W - DIGIT_W));
            bksp_val  = dout << DIGIT_W;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= HELD;
            db_cnt <= '0;
            dout   <= '0;
            count  <= '0;
            ena    <= 1'b0;
            done   <= 1'b0;
            word   <= '0;
        end else begin
            ena  <= 1'b0;
            done <= 1'b0;

            case (state)
                IDLE: begin
                    if (!key_n) begin
                        state  <= HELD;
                        db_cnt <= '0;
                    end
                end
                HELD: begin
                    if (key_n) begin
                        if (db_cnt == DW'(DEBOUNCE - 1)) begin
                            state  <= IDLE;
                            db_cnt <= '0;
                        end else begin
                            db_cnt <= db_cnt + DW'(1);
                        end
                    end else begin
                        db_cnt <= '0;
                    end
                end
                default: begin
                    state  <= HELD;
                    db_cnt <= '0;
                end
            endcase

            // A press coincident with clr/commit/bksp is consumed by the FSM above but not captured.
            if (clr) begin
                dout  <= '0;
                count <= '0;
            end else if (commit) begin
                word <= dout;
                done <= 1'b1;
                if (CLR_ON_COMMIT != 0) begin
                    dout  <= '0;
                    count <= '0;
                end
            end else if (bksp) begin
                if (count != '0) begin
                    count <= count - CW'(1);
                    dout  <= bksp_val;
                end
            end else if (press) begin
                if (!full) begin
                    dout  <= shift_val;
                    count <= count + CW'(1);
                    ena   <= 1'b1;
                end else if (FULL_MODE != 0) begin
                    dout <= shift_val;
                    ena  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_shift_in_param.sv
// Bench for shift_in_param: three instances (default, overwrite-when-full, LSB-entry) share
// one stimulus stream and are checked every cycle against a digit-list reference model.
module tb_shift_in_param;

    localparam int DIGIT_W = 4;
    localparam int DIGITS  = 4;
    localparam int DEB     = 2;
    localparam int NI      = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        key_n = 1'b1;
    logic [3:0]  din = '0;
    logic        clr = 1'b0;
    logic        bksp = 1'b0;
    logic        commit = 1'b0;

    logic [15:0] dout_a [NI];
    logic [2:0]  cnt_a  [NI];
    logic        full_a [NI];
    logic        ena_a  [NI];
    logic        done_a [NI];
    logic [15:0] word_a [NI];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    shift_in_param #(.DIGIT_W(4), .DIGITS(4), .MSB_FIRST(1), .FULL_MODE(0), .DEBOUNCE(DEB), .CLR_ON_COMMIT(1)) dut0 (
        .clk(clk), .rst(rst), .key_n(key_n), .din(din), .clr(clr), .bksp(bksp), .commit(commit),
        .dout(dout_a[0]), .count(cnt_a[0]), .full(full_a[0]), .ena(ena_a[0]), .done(done_a[0]), .word(word_a[0]));

    shift_in_param #(.DIGIT_W(4), .DIGITS(4), .MSB_FIRST(1), .FULL_MODE(1), .DEBOUNCE(DEB), .CLR_ON_COMMIT(1)) dut1 (
        .clk(clk), .rst(rst), .key_n(key_n), .din(din), .clr(clr), .bksp(bksp), .commit(commit),
        .dout(dout_a[1]), .count(cnt_a[1]), .full(full_a[1]), .ena(ena_a[1]), .done(done_a[1]), .word(word_a[1]));

    shift_in_param #(.DIGIT_W(4), .DIGITS(4), .MSB_FIRST(0), .FULL_MODE(0), .DEBOUNCE(DEB), .CLR_ON_COMMIT(1)) dut2 (
        .clk(clk), .rst(rst), .key_n(key_n), .din(din), .clr(clr), .bksp(bksp), .commit(commit),
        .dout(dout_a[2]), .count(cnt_a[2]), .full(full_a[2]), .ena(ena_a[2]), .done(done_a[2]), .word(word_a[2]));

    // ---------------- reference model: ordered list of entered digits ----------------
    int          m_msb [NI] = '{1, 1, 0};
    int          m_fm  [NI] = '{0, 1, 0};
    int          md    [NI][DIGITS];
    int          mcnt  [NI];
    logic [15:0] mword [NI];
    logic        mena  [NI];
    logic        mdone [NI];
    int          armed;
    int          run;

    function automatic logic [15:0] mval(input int k);
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < mcnt[k]; i++) begin
            if (m_msb[k] != 0) v = (v << 4) | 16'(md[k][i]);
            else               v = v | (16'(md[k][i]) << (4 * (DIGITS - mcnt[k] + i)));
        end
        return v;
    endfunction

    task automatic model_step();
        int press;
        press = 0;
        if (!rst) begin
            armed = 0;
            run   = 0;
            for (int k = 0; k < NI; k++) begin
                mcnt[k] = 0; mword[k] = '0; mena[k] = 1'b0; mdone[k] = 1'b0;
            end
            return;
        end
        if (armed != 0) begin
            if (!key_n) begin press = 1; armed = 0; run = 0; end
        end else if (key_n) begin
            run++;
            if (run >= DEB) begin armed = 1; run = 0; end
        end else begin
            run = 0;
        end
        for (int k = 0; k < NI; k++) begin
            mena[k]  = 1'b0;
            mdone[k] = 1'b0;
            if (clr) begin
                mcnt[k] = 0;
            end else if (commit) begin
                mword[k] = mval(k);
                mdone[k] = 1'b1;
                mcnt[k]  = 0;
            end else if (bksp) begin
                if (mcnt[k] > 0) mcnt[k]--;
            end else if (press != 0) begin
                if (mcnt[k] < DIGITS) begin
                    md[k][mcnt[k]] = int'(din);
                    mcnt[k]++;
                    mena[k] = 1'b1;
                end else if (m_fm[k] != 0) begin
                    for (int i = 0; i < DIGITS - 1; i++) md[k][i] = md[k][i+1];
                    md[k][DIGITS-1] = int'(din);
                    mena[k] = 1'b1;
                end
            end
        end
    endtask

    task automatic check(input string name, input int k, input logic [15:0] act, input logic [15:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s inst%0d @%0t: got %h expected %h", name, k, $time, act, exp_v);
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < NI; k++) begin
            check("dout",  k, dout_a[k], mval(k));
            check("count", k, 16'(cnt_a[k]), 16'(mcnt[k]));
            check("full",  k, 16'(full_a[k]), 16'(mcnt[k] == DIGITS));
            check("ena",   k, 16'(ena_a[k]), 16'(mena[k]));
            check("done",  k, 16'(done_a[k]), 16'(mdone[k]));
            check("word",  k, word_a[k], mword[k]);
        end
    endtask

    // One clock: model follows the edge, outputs are sampled 1 time unit later.
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic drive(input logic k_n, input logic [3:0] d, input logic c, input logic b, input logic cm);
        key_n = k_n; din = d; clr = c; bksp = b; commit = cm;
    endtask

    // ---------------- directed table for instance 0 ----------------
    typedef struct {
        logic        key_n;
        logic [3:0]  din;
        logic        clr;
        logic        bksp;
        logic        commit;
        logic [15:0] e_dout;
        logic [2:0]  e_count;
        logic        e_ena;
        logic        e_done;
        logic [15:0] e_word;
    } vec_t;

    vec_t tbl[$];

    function automatic void row(input logic k_n, input logic [3:0] d, input logic c, input logic b,
                                input logic cm, input logic [15:0] ed, input logic [2:0] ec,
                                input logic ee, input logic edn, input logic [15:0] ew);
        vec_t r;
        r.key_n = k_n; r.din = d; r.clr = c; r.bksp = b; r.commit = cm;
        r.e_dout = ed; r.e_count = ec; r.e_ena = ee; r.e_done = edn; r.e_word = ew;
        tbl.push_back(r);
    endfunction

    function automatic void fill_table();
        logic [3:0]  digs [4];
        logic [15:0] ev;
        digs = '{4'h5, 4'h9, 4'h6, 4'hA};
        ev = '0;
        row(1, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
        row(1, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            ev = (ev << 4) | 16'(digs[i]);
            row(0, digs[i], 0, 0, 0, ev, 3'(i + 1), 1, 0, 0);
            row(0, digs[i], 0, 0, 0, ev, 3'(i + 1), 0, 0, 0);
            for (int j = 0; j < 3; j++) row(1, 0, 0, 0, 0, ev, 3'(i + 1), 0, 0, 0);
        end
        // press when full is consumed without capture
        row(0, 4'hF, 0, 0, 0, 16'h596A, 4, 0, 0, 0);
        row(0, 4'hF, 0, 0, 0, 16'h596A, 4, 0, 0, 0);
        for (int j = 0; j < 3; j++) row(1, 0, 0, 0, 0, 16'h596A, 4, 0, 0, 0);
        row(1, 0, 0, 1, 0, 16'h0596, 3, 0, 0, 0);
        // commit wins over a simultaneous press
        row(0, 4'h7, 0, 0, 1, 16'h0000, 0, 0, 1, 16'h0596);
        row(0, 4'h7, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0596);
        row(1, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0596);
        row(1, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0596);
        row(0, 4'h3, 0, 0, 0, 16'h0003, 1, 1, 0, 16'h0596);
        row(1, 0, 0, 0, 0, 16'h0003, 1, 0, 0, 16'h0596);
        row(1, 0, 0, 0, 0, 16'h0003, 1, 0, 0, 16'h0596);
        row(1, 0, 1, 0, 0, 16'h0000, 0, 0, 0, 16'h0596);
        row(1, 0, 0, 1, 0, 16'h0000, 0, 0, 0, 16'h0596);
        // long hold, short bounce, then a properly debounced second press
        row(0, 4'h7, 0, 0, 0, 16'h0007, 1, 1, 0, 16'h0596);
        for (int j = 0; j < 9; j++) row(0, 4'h7, 0, 0, 0, 16'h0007, 1, 0, 0, 16'h0596);
        row(1, 0, 0, 0, 0, 16'h0007, 1, 0, 0, 16'h0596);
        row(0, 4'h8, 0, 0, 0, 16'h0007, 1, 0, 0, 16'h0596);
        row(0, 4'h8, 0, 0, 0, 16'h0007, 1, 0, 0, 16'h0596);
        row(1, 0, 0, 0, 0, 16'h0007, 1, 0, 0, 16'h0596);
        row(1, 0, 0, 0, 0, 16'h0007, 1, 0, 0, 16'h0596);
        row(0, 4'h8, 0, 0, 0, 16'h0078, 2, 1, 0, 16'h0596);
        row(1, 0, 0, 0, 0, 16'h0078, 2, 0, 0, 16'h0596);
        row(1, 0, 0, 0, 0, 16'h0078, 2, 0, 0, 16'h0596);
    endfunction

    initial begin
        fill_table();

        // reset
        rst = 1'b0;
        drive(1, 0, 0, 0, 0);
        cyc();
        cyc();
        check("rst_dout", 0, dout_a[0], 16'h0000);
        check("rst_word", 0, word_a[0], 16'h0000);
        rst = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].key_n, tbl[i].din, tbl[i].clr, tbl[i].bksp, tbl[i].commit);
            cyc();
            check($sformatf("tbl%0d_dout", i),  0, dout_a[0], tbl[i].e_dout);
            check($sformatf("tbl%0d_count", i), 0, 16'(cnt_a[0]), 16'(tbl[i].e_count));
            check($sformatf("tbl%0d_ena", i),   0, 16'(ena_a[0]), 16'(tbl[i].e_ena));
            check($sformatf("tbl%0d_done", i),  0, 16'(done_a[0]), 16'(tbl[i].e_done));
            check($sformatf("tbl%0d_word", i),  0, word_a[0], tbl[i].e_word);
        end

        // key held low through reset on the LSB-entry instance
        drive(0, 4'h4, 0, 0, 0);
        rst = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
        for (int j = 0; j < 3; j++) begin
            cyc();
            check("held_rst_dout", 2, dout_a[2], 16'h0000);
            check("held_rst_ena",  2, 16'(ena_a[2]), 16'h0000);
        end
        drive(1, 0, 0, 0, 0); cyc();
        drive(0, 4'h4, 0, 0, 0); cyc();
        check("bounce_ena", 2, 16'(ena_a[2]), 16'h0000);
        drive(1, 0, 0, 0, 0); cyc(); cyc();
        drive(0, 4'h5, 0, 0, 0); cyc();
        check("lsb_first5", 2, dout_a[2], 16'h5000);
        check("lsb_ena5",   2, 16'(ena_a[2]), 16'h0001);
        drive(1, 0, 0, 0, 0); cyc(); cyc();
        drive(0, 4'h9, 0, 0, 0); cyc();
        check("lsb_then9", 2, dout_a[2], 16'h9500);
        drive(1, 0, 0, 0, 0); cyc(); cyc();

        // randomized traffic against the model
        for (int n = 0; n < 2500; n++) begin
            logic k_n;
            k_n = ($urandom_range(0, 3) != 0) ? key_n : ~key_n;
            drive(k_n, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 39) == 0,
                  $urandom_range(0, 11) == 0,
                  $urandom_range(0, 29) == 0);
            rst = ($urandom_range(0, 299) != 0);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
